// File: rtl/stopwatch_core_n.sv
// rtl/stopwatch_core_n.sv - N-digit BCD stopwatch: run/pause/idle FSM, tick prescaler, multiplexed 7-seg scan
// Optional lap freeze/display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core_n #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 1200000,
   parameter int SCAN_DIV = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btn_clear,
   input  logic                btn_stop,
   input  logic                btn_start,
   input  logic                btn_lap,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   digit_en,
   output logic [4*DIGITS-1:0] count,
   output logic                running,
   output logic                lap_active,
   output logic                ovf
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE
   } state_t;

   state_t              state;
   logic                clear_q;
   logic                stop_q;
   logic                start_q;
   logic                lap_q;
   logic                rise_clear;
   logic                rise_stop;
   logic                rise_start;
   logic                rise_lap;
   logic                lap_blocked;
   logic                run_now;
   logic                tick;
   logic                all_nines;
   logic [PW-1:0]       presc;
   logic [4*DIGITS-1:0] count_inc;
   logic [4*DIGITS-1:0] disp_val;
   logic [SW-1:0]       scan_cnt;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       idx_next;
   logic                dp_next;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clear_q <= 1'b0;
         stop_q  <= 1'b0;
         start_q <= 1'b0;
         lap_q   <= 1'b0;
      end else begin
         clear_q <= btn_clear;
         stop_q  <= btn_stop;
         start_q <= btn_start;
         lap_q   <= btn_lap;
      end
   end

   assign rise_clear = btn_clear & ~clear_q;
   assign rise_stop  = btn_stop  & ~stop_q;
   assign rise_start = btn_start & ~start_q;
   assign rise_lap   = btn_lap   & ~lap_q;

   // A lap edge yields to any higher-priority edge that actually acts this cycle.
   assign lap_blocked = rise_clear
                      | (rise_stop  & (state == S_RUN))
                      | (rise_start & (state != S_RUN));

   // Counting stops on the very edge that leaves RUN, so running and counting agree.
   assign run_now = (state == S_RUN) & ~rise_clear & ~rise_stop;
   assign tick    = run_now & (presc == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         running <= 1'b0;
      end else if (rise_clear) begin
         state   <= S_IDLE;
         running <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (rise_stop) begin
                  state   <= S_PAUSE;
                  running <= 1'b0;
               end
            end
            S_IDLE, S_PAUSE: begin
               if (rise_start) begin
                  state   <= S_RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      logic carry;
      carry     = 1'b1;
      count_inc = count;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (count[4*i +: 4] >= 4'd9) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      all_nines = carry;
   end

   // Prescaler is held (not cleared) in PAUSE so a partial tick survives the pause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         ovf <= tick & all_nines;
         if (rise_clear || state == S_IDLE) begin
            presc <= '0;
            count <= '0;
         end else if (run_now) begin
            if (presc == TICK_LAST) begin
               presc <= '0;
               count <= count_inc;
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [4*DIGITS-1:0] lap_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_reg    <= '0;
         lap_active <= 1'b0;
      end else if (rise_clear) begin
         lap_reg    <= '0;
         lap_active <= 1'b0;
      end else if (rise_lap && !lap_blocked) begin
         if (lap_active) begin
            lap_active <= 1'b0;
         end else if (state == S_RUN) begin
            lap_reg    <= count;
            lap_active <= 1'b1;
         end
      end
   end

   assign disp_val = lap_active ? lap_reg : count;
`else
   logic unused_lap;
   assign unused_lap = rise_lap | lap_blocked;
   assign lap_active = 1'b0;
   assign disp_val   = count;
`endif

   assign idx_next = (idx == DIGIT_LAST) ? '0 : idx + 1'b1;

   always_comb begin
      dp_next = 1'b1;
      if (DIGITS > 2) begin
         dp_next = (idx_next != IW'(2));
      end else begin
         dp_next = ~((idx_next == IW'(1)) & lap_active);
      end
   end

   // Display registers load only on a digit advance; all digits stay dark until the first one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
         seg      <= 7'h7F;
         dp       <= 1'b1;
         digit_en <= '1;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= idx_next;
         seg      <= seg_of(disp_val[4*idx_next +: 4]);
         dp       <= dp_next;
         digit_en <= ~(DIGITS'(1) << idx_next);
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_stopwatch_core_n.sv
// tb/tb_stopwatch_core_n.sv - directed self-checking bench for stopwatch_core_n (DIGITS=4, TICK_DIV=4, SCAN_DIV=4)
module tb_stopwatch_core_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_clear;
   logic        btn_stop;
   logic        btn_start;
   logic        btn_lap;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  digit_en;
   logic [15:0] count;
   logic        running;
   logic        lap_active;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stopwatch_core_n #(
      .DIGITS   (4),
      .TICK_DIV (4),
      .SCAN_DIV (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_clear  (btn_clear),
      .btn_stop   (btn_stop),
      .btn_start  (btn_start),
      .btn_lap    (btn_lap),
      .seg        (seg),
      .dp         (dp),
      .digit_en   (digit_en),
      .count      (count),
      .running    (running),
      .lap_active (lap_active),
      .ovf        (ovf)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [6:0] seg_exp(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic int idx_of(input logic [3:0] en);
      case (en)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic do_reset;
      btn_clear = 1'b0;
      btn_stop  = 1'b0;
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      #2 rst_n  = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic press_start;
      btn_start = 1'b1;
      step(1);
      btn_start = 1'b0;
   endtask

   task automatic press_stop;
      btn_stop = 1'b1;
      step(1);
      btn_stop = 1'b0;
   endtask

   task automatic press_lap;
      btn_lap = 1'b1;
      step(1);
      btn_lap = 1'b0;
   endtask

   task automatic check_scan(input logic [15:0] disp, input string tag);
      int i;
      for (int c = 0; c < 16; c++) begin
         i = idx_of(digit_en);
         total++;
         if (i < 0) begin
            bad++;
            $display("FAIL %s_digit_en: got %b want one-hot-low", tag, digit_en);
         end else begin
            if (seg !== seg_exp(disp[4*i +: 4])) begin
               bad++;
               $display("FAIL %s_seg[%0d]: got %h want %h", tag, i, seg, seg_exp(disp[4*i +: 4]));
            end
            total++;
            if (dp !== ((i == 2) ? 1'b0 : 1'b1)) begin
               bad++;
               $display("FAIL %s_dp[%0d]: got %b want %b", tag, i, dp, (i == 2) ? 1'b0 : 1'b1);
            end
         end
         step(1);
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      btn_clear = 1'b0;
      btn_stop  = 1'b0;
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      step(2);
      total++; if (seg !== 7'h7F)       begin bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
      total++; if (dp !== 1'b1)         begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
      total++; if (digit_en !== 4'hF)   begin bad++; $display("FAIL reset_digit_en: got %b want 1111", digit_en); end
      total++; if (count !== 16'h0000)  begin bad++; $display("FAIL reset_count: got %h want 0000", count); end
      total++; if (running !== 1'b0)    begin bad++; $display("FAIL reset_running: got %b want 0", running); end
      total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL reset_lap_active: got %b want 0", lap_active); end
      total++; if (ovf !== 1'b0)        begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
   endtask

   task automatic test_scan;
      logic [3:0] seq [0:4];
      seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
      rst_n = 1'b1;
      step(3);
      total++; if (digit_en !== 4'hF) begin bad++; $display("FAIL scan_pre_digit_en: got %b want 1111", digit_en); end
      total++; if (seg !== 7'h7F)     begin bad++; $display("FAIL scan_pre_seg: got %h want 7f", seg); end
      step(1);
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 4; j++) begin
            total++;
            if (digit_en !== seq[k]) begin
               bad++;
               $display("FAIL scan_digit_en[%0d.%0d]: got %b want %b", k, j, digit_en, seq[k]);
            end
            if (j == 0) begin
               total++;
               if (seg !== 7'h40) begin bad++; $display("FAIL scan_seg[%0d]: got %h want 40", k, seg); end
               total++;
               if (dp !== ((k == 1) ? 1'b0 : 1'b1)) begin
                  bad++;
                  $display("FAIL scan_dp[%0d]: got %b want %b", k, dp, (k == 1) ? 1'b0 : 1'b1);
               end
            end
            step(1);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (digit_en !== 4'hF) begin bad++; $display("FAIL async_digit_en: got %b want 1111", digit_en); end
      total++; if (seg !== 7'h7F)     begin bad++; $display("FAIL async_seg: got %h want 7f", seg); end
      total++; if (dp !== 1'b1)       begin bad++; $display("FAIL async_dp: got %b want 1", dp); end
      step(1);
      rst_n = 1'b1;
   endtask

   task automatic test_count;
      do_reset();
      press_start();
      total++; if (running !== 1'b1)   begin bad++; $display("FAIL count_start_running: got %b want 1", running); end
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL count_start_count: got %h want 0000", count); end
      step(40);
      total++; if (count !== 16'h0010) begin bad++; $display("FAIL count_40: got %h want 0010", count); end
      total++; if (running !== 1'b1)   begin bad++; $display("FAIL count_40_running: got %b want 1", running); end
      press_stop();
      total++; if (running !== 1'b0)   begin bad++; $display("FAIL count_stop_running: got %b want 0", running); end
      step(20);
      total++; if (count !== 16'h0010) begin bad++; $display("FAIL count_frozen: got %h want 0010", count); end
   endtask

   task automatic test_pause;
      do_reset();
      press_start();
      step(6);
      total++; if (count !== 16'h0001) begin bad++; $display("FAIL pause_pre: got %h want 0001", count); end
      press_stop();
      total++; if (running !== 1'b0)   begin bad++; $display("FAIL pause_running: got %b want 0", running); end
      step(1);
      press_lap();
      total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL pause_lap_ignored: got %b want 0", lap_active); end
      step(4);
      total++; if (count !== 16'h0001) begin bad++; $display("FAIL pause_hold: got %h want 0001", count); end
      press_start();
      total++; if (running !== 1'b1)   begin bad++; $display("FAIL resume_running: got %b want 1", running); end
      step(1);
      total++; if (count !== 16'h0001) begin bad++; $display("FAIL resume_plus1: got %h want 0001", count); end
      step(1);
      total++; if (count !== 16'h0002) begin bad++; $display("FAIL resume_plus2: got %h want 0002", count); end
      step(3);
      #2 rst_n = 1'b0;
      #1;
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL async_count: got %h want 0000", count); end
      total++; if (running !== 1'b0)   begin bad++; $display("FAIL async_running: got %b want 0", running); end
      step(1);
      rst_n = 1'b1;
   endtask

   task automatic test_hold;
      do_reset();
      btn_clear = 1'b1;
      step(1);
      press_start();
      step(8);
      total++; if (running !== 1'b1)   begin bad++; $display("FAIL hold_running: got %b want 1", running); end
      total++; if (count !== 16'h0002) begin bad++; $display("FAIL hold_count: got %h want 0002", count); end
      btn_clear = 1'b0;
      step(1);
      total++; if (count !== 16'h0002) begin bad++; $display("FAIL hold_release: got %h want 0002", count); end
   endtask

   task automatic test_clear_start;
      do_reset();
      btn_clear = 1'b1;
      btn_start = 1'b1;
      step(1);
      btn_clear = 1'b0;
      btn_start = 1'b0;
      total++; if (running !== 1'b0)   begin bad++; $display("FAIL cs_idle_running: got %b want 0", running); end
      step(8);
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL cs_idle_count: got %h want 0000", count); end
      press_start();
      step(6);
      total++; if (count !== 16'h0001) begin bad++; $display("FAIL cs_run_pre: got %h want 0001", count); end
      btn_clear = 1'b1;
      btn_start = 1'b1;
      step(1);
      btn_clear = 1'b0;
      btn_start = 1'b0;
      total++; if (running !== 1'b0)   begin bad++; $display("FAIL cs_run_running: got %b want 0", running); end
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL cs_run_count: got %h want 0000", count); end
   endtask

   task automatic test_lap;
      do_reset();
      press_start();
      step(48);
      total++; if (count !== 16'h0012) begin bad++; $display("FAIL lap_pre: got %h want 0012", count); end
      press_lap();
`ifdef STOPWATCH_LAP_EN
      total++; if (lap_active !== 1'b1) begin bad++; $display("FAIL lap_set: got %b want 1", lap_active); end
      step(20);
      total++; if (count !== 16'h0017) begin bad++; $display("FAIL lap_live: got %h want 0017", count); end
      check_scan(16'h0012, "lap_frozen");
      total++; if (lap_active !== 1'b1) begin bad++; $display("FAIL lap_still: got %b want 1", lap_active); end
      press_lap();
      total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL lap_release: got %b want 0", lap_active); end
      press_stop();
      total++; if (count !== 16'h0021) begin bad++; $display("FAIL lap_after: got %h want 0021", count); end
      step(16);
      check_scan(16'h0021, "lap_live");
`else
      total++; if (lap_active !== 1'b0) begin bad++; $display("FAIL lap_tied: got %b want 0", lap_active); end
      press_stop();
      total++; if (count !== 16'h0012) begin bad++; $display("FAIL lap_stop: got %h want 0012", count); end
      step(16);
      check_scan(16'h0012, "nolap_live");
`endif
   endtask

   task automatic test_ovf;
      do_reset();
      press_start();
      step(39996);
      total++; if (count !== 16'h9999) begin bad++; $display("FAIL ovf_preload: got %h want 9999", count); end
      total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL ovf_pre: got %b want 0", ovf); end
      step(3);
      total++; if (count !== 16'h9999) begin bad++; $display("FAIL ovf_hold: got %h want 9999", count); end
      step(1);
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL ovf_wrap: got %h want 0000", count); end
      total++; if (ovf !== 1'b1)       begin bad++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
      step(1);
      total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL ovf_single: got %b want 0", ovf); end
      total++; if (count !== 16'h0000) begin bad++; $display("FAIL ovf_after: got %h want 0000", count); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_count();
      test_pause();
      test_hold();
      test_clear_start();
      test_lap();
      test_ovf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
